lane_rx_crc_array: RTL and testbench
====================================

LANE_RX_CRC_ARRAY -- requirements
Module: lane_rx_crc_array

Interface
REQ-001 Parameter NUM_LANES, default 4: number of independent Interlaken receive lanes checked (1..24).
REQ-002 Parameter CNT_W, default 16: width of each lane's error counter.
REQ-003 Parameter ALARM_THRESH, default 4: consecutive bad metaframes that raise a lane alarm (1..15).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 arst_n  input  1  asynchronous active-low reset.
REQ-006 din  input  64*NUM_LANES  lane i word at bits [64*i+63:64*i], bit 63 first on the wire.
REQ-007 din_fresh  input  NUM_LANES  lane i word valid this cycle.
REQ-008 diag_word  input  NUM_LANES  qualifies lane i's same-cycle fresh word as the diagnostic (last) word of a metaframe.
REQ-009 lane_enable  input  NUM_LANES  lane i checking enabled.
REQ-010 cnt_clear  input  1  synchronous clear of all error counters and alarms.
REQ-011 crc_ok  output  NUM_LANES  one-cycle pulse: lane i metaframe CRC matched.
REQ-012 crc_error  output  NUM_LANES  one-cycle pulse: lane i metaframe CRC mismatched.
REQ-013 lane_alarm  output  NUM_LANES  level: lane i has ALARM_THRESH or more consecutive bad metaframes.
REQ-014 err_cnt  output  CNT_W*NUM_LANES  lane i saturating mismatch count at bits [CNT_W*i+CNT_W-1:CNT_W*i].

Function
REQ-015 The block SHALL instantiate NUM_LANES identical, fully independent lane checkers; the only cross-lane signal SHALL be cnt_clear.
REQ-016 The CRC SHALL be CRC-32C (poly 0x1EDC6F41), non-reflected, 64 bits per fresh word, MSB first, running value seeded to 0xFFFFFFFF.
REQ-017 The CRC SHALL cover every fresh word of the metaframe, with the diagnostic word's bits [31:0] replaced by zero before accumulation.
REQ-018 A metaframe SHALL match when diagnostic-word bits [31:0] equal the bitwise complement of the final running CRC.
REQ-019 The per-lane state machine SHALL have states HUNT and CHECK; reset and lane_enable=0 SHALL force HUNT.
REQ-020 HUNT: a fresh diag word SHALL reseed the CRC for the next word and move to CHECK, without emitting crc_ok or crc_error.
REQ-021 CHECK: a fresh diag word SHALL complete the comparison, emit exactly one of crc_ok/crc_error, reseed the CRC, and remain in CHECK.
REQ-022 The result pulse SHALL appear exactly 4 clk cycles after the cycle holding the fresh diag word, for every lane.
REQ-023 din_fresh SHALL be accepted every cycle; non-fresh cycles SHALL leave CRC state unchanged; back-to-back diag words (one-word metaframes) SHALL be checked correctly.
REQ-024 diag_word with din_fresh=0 SHALL be ignored.
REQ-025 On crc_error, err_cnt SHALL increment by 1 in the pulse cycle, saturating at 2^CNT_W-1.
REQ-026 A per-lane 4-bit consecutive-bad counter SHALL increment on crc_error, saturating at 15, and clear on crc_ok.
REQ-027 lane_alarm SHALL assert the cycle after the consecutive-bad counter reaches ALARM_THRESH, and deassert the cycle after a crc_ok.
REQ-028 cnt_clear SHALL zero all err_cnt, consecutive-bad counters, and lane_alarm the next cycle; a same-cycle crc_error increment SHALL be discarded (clear wins).
REQ-029 Deasserting lane_enable SHALL flush that lane's in-flight pipeline: no result pulses for diag words less than 4 cycles old. It SHALL clear the consecutive-bad counter and lane_alarm, but SHALL retain err_cnt.

Reset
REQ-030 While arst_n=0, crc_ok, crc_error, lane_alarm, err_cnt, all pipeline registers and the CRC state SHALL be 0, and every lane SHALL be in HUNT.
REQ-031 Reset assertion SHALL take effect asynchronously; after release, the first diag word on each lane SHALL only enter CHECK (no result).

Verification
REQ-032 Lane 0, three 8-word metaframes with correct CRC -> first diag word silent, two crc_ok pulses each 4 cycles after diag, err_cnt[0]=0.
REQ-033 Lane 1, five consecutive metaframes with CRC bit 0 flipped after sync, ALARM_THRESH=4 -> five crc_error pulses, err_cnt[1]=5, lane_alarm[1] high from the cycle after the 4th error; then one good metaframe -> alarm low.
REQ-034 CNT_W=2, six bad metaframes -> err_cnt holds at 3.
REQ-035 cnt_clear in the same cycle as a crc_error pulse -> err_cnt=0 and lane_alarm=0 the next cycle.
REQ-036 All lanes with random din_fresh gaps and one-word metaframes, lane 2 disabled 2 cycles after a bad diag word -> no pulse on lane 2, other lanes match the reference model bit-exactly.
REQ-037 arst_n pulsed low mid-metaframe -> all outputs 0; the next diag word is silent.

Source files
------------

// File: rtl/lane_rx_crc_array.sv
// Per-lane Interlaken metaframe CRC-32C checker array.
// Each lane: HUNT/CHECK sync, 4-cycle result pipe, error/alarm counters.
module lane_rx_crc_array #(
  parameter int NUM_LANES    = 4,
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic [64*NUM_LANES-1:0]    din,
  input  logic [NUM_LANES-1:0]       din_fresh,
  input  logic [NUM_LANES-1:0]       diag_word,
  input  logic [NUM_LANES-1:0]       lane_enable,
  input  logic                       cnt_clear,
  output logic [NUM_LANES-1:0]       crc_ok,
  output logic [NUM_LANES-1:0]       crc_error,
  output logic [NUM_LANES-1:0]       lane_alarm,
  output logic [CNT_W*NUM_LANES-1:0] err_cnt
);

  localparam logic [31:0] POLY = 32'h1EDC6F41;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  typedef enum logic {HUNT, CHECK} st_e;

  function automatic logic [31:0] crc64(
    input logic [31:0] c,
    input logic [63:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 63; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [63:0]      w, wm;
    logic             fr, dg, en;
    st_e              st_q, st_d;
    logic [31:0]      crc_q, crc_d, crc_nx;
    logic             match;
    logic [2:0]       pv_q, pv_d, pk_q, pk_d;
    logic             ok_q, ok_d, er_q, er_d;
    logic             al_q, al_d;
    logic [3:0]       bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w  = din[64*g +: 64];
    assign fr = din_fresh[g];
    assign dg = diag_word[g];
    assign en = lane_enable[g];

    // Diag word carries its own CRC in [31:0]; that field is zeroed.
    assign wm     = {w[63:32], dg ? 32'h0 : w[31:0]};
    assign crc_nx = crc64(crc_q, wm);
    assign match  = (w[31:0] == ~crc_nx);

    always_comb begin
      st_d  = st_q;
      crc_d = crc_q;
      pv_d  = {pv_q[1:0], 1'b0};
      pk_d  = {pk_q[1:0], match};
      ok_d  = pv_q[2] & pk_q[2];
      er_d  = pv_q[2] & ~pk_q[2];
      bad_d = bad_q;
      cnt_d = cnt_q;
      if (fr) begin
        if (dg) begin
          crc_d   = SEED;
          pv_d[0] = (st_q == CHECK);
          st_d    = CHECK;
        end else begin
          crc_d = crc_nx;
        end
      end
      if (er_q) begin
        if (bad_q != 4'hF) bad_d = bad_q + 4'd1;
        if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
      end
      if (ok_q) bad_d = '0;
      al_d = (bad_d >= 4'(ALARM_THRESH));
      // Disabling drops in-flight results but keeps the error history.
      if (!en) begin
        st_d  = HUNT;
        crc_d = '0;
        pv_d  = '0;
        pk_d  = '0;
        ok_d  = 1'b0;
        er_d  = 1'b0;
        bad_d = '0;
        al_d  = 1'b0;
      end
      if (cnt_clear) begin
        cnt_d = '0;
        bad_d = '0;
        al_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        st_q  <= HUNT;
        crc_q <= '0;
        pv_q  <= '0;
        pk_q  <= '0;
        ok_q  <= 1'b0;
        er_q  <= 1'b0;
        al_q  <= 1'b0;
        bad_q <= '0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        crc_q <= crc_d;
        pv_q  <= pv_d;
        pk_q  <= pk_d;
        ok_q  <= ok_d;
        er_q  <= er_d;
        al_q  <= al_d;
        bad_q <= bad_d;
        cnt_q <= cnt_d;
      end
    end

    assign crc_ok[g]                = ok_q;
    assign crc_error[g]             = er_q;
    assign lane_alarm[g]            = al_q;
    assign err_cnt[CNT_W*g +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_lane_rx_crc_array.sv
// Directed bench for lane_rx_crc_array: sync, ok/error, alarm,
// saturation, clear, random gaps with lane disable, async reset.
module tb_lane_rx_crc_array;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic [255:0] din = '0;
  logic [3:0]   fresh = '0;
  logic [3:0]   diag = '0;
  logic [3:0]   en = 4'hF;
  logic         clr = 1'b0;
  logic [3:0]   ok, er, al;
  logic [63:0]  cnt;
  logic         ok2, er2, al2;
  logic [1:0]   cnt2;

  lane_rx_crc_array #(.NUM_LANES(4), .CNT_W(16), .ALARM_THRESH(4)) dut (
    .clk(clk), .arst_n(arst_n), .din(din), .din_fresh(fresh),
    .diag_word(diag), .lane_enable(en), .cnt_clear(clr),
    .crc_ok(ok), .crc_error(er), .lane_alarm(al), .err_cnt(cnt)
  );

  lane_rx_crc_array #(.NUM_LANES(1), .CNT_W(2), .ALARM_THRESH(4)) dut2 (
    .clk(clk), .arst_n(arst_n), .din(din[63:0]), .din_fresh(fresh[0]),
    .diag_word(diag[0]), .lane_enable(en[0]), .cnt_clear(clr),
    .crc_ok(ok2), .crc_error(er2), .lane_alarm(al2), .err_cnt(cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int okn[4] = '{0, 0, 0, 0};
  int ern[4] = '{0, 0, 0, 0};
  always @(negedge clk)
    for (int l = 0; l < 4; l++) begin
      if (ok[l]) okn[l]++;
      if (er[l]) ern[l]++;
    end

  int n_cmp = 0;
  int n_bad = 0;
  int dcyc  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference CRC: xor each 32-bit half in, then shift 32 times.
  function automatic logic [31:0] step(input logic [31:0] c,
                                       input logic [63:0] w);
    logic [31:0] r;
    r = c;
    for (int h = 0; h < 2; h++) begin
      r ^= (h == 0) ? w[63:32] : w[31:0];
      for (int k = 0; k < 32; k++)
        r = r[31] ? ({r[30:0], 1'b0} ^ 32'h1EDC6F41) : {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [63:0] mkw(input int s, input int i);
    return {32'(s * 7919 + i), 32'(i * 104729 ^ s)} ^ 64'hA5A50F0F3C3C9696;
  endfunction

  task automatic upto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic put(input int l, input logic [63:0] w, input bit d);
    din[64*l +: 64] = w;
    fresh[l] = 1'b1;
    diag[l]  = d;
    if (d) dcyc = cyc;
    @(negedge clk);
    fresh[l] = 1'b0;
    diag[l]  = 1'b0;
  endtask

  task automatic frame(input int l, input int n, input bit bad,
                       input int s);
    logic [31:0] c, fin;
    logic [63:0] w;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 1; i++) begin
      w = mkw(s, i);
      put(l, w, 1'b0);
      c = step(c, w);
    end
    w = mkw(s, 99);
    fin = step(c, {w[63:32], 32'h0});
    put(l, {w[63:32], ~fin ^ {31'b0, bad}}, 1'b1);
  endtask

  logic [31:0] mcrc[4];
  bit          mchk[4];
  bit          rok[4][8];
  bit          rer[4][8];
  int          merr[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d4, okb, c;
    logic [3:0] eo, ee;
    logic [63:0] w;
    logic [31:0] fin;
    bit f, d, b;

    repeat (3) @(negedge clk);
    chk("rst_ok", ok, 0);
    chk("rst_err", er, 0);
    chk("rst_alarm", al, 0);
    chk("rst_cnt", cnt, 0);
    arst_n = 1'b1;
    @(negedge clk);

    // Lane 0: three good 8-word metaframes, first only syncs.
    frame(0, 8, 0, 1);
    frame(0, 8, 0, 2);
    frame(0, 8, 0, 3);
    d4 = dcyc;
    upto(d4 + 3);
    chk("l0_ok_early", ok[0], 0);
    @(negedge clk);
    chk("l0_ok_lat4", ok[0], 1);
    @(negedge clk);
    chk("l0_ok_1cyc", ok[0], 0);
    chk("l0_ok_count", okn[0], 2);
    chk("l0_err_count", ern[0], 0);
    chk("l0_cnt", cnt[15:0], 0);

    // Lane 1: sync, five bad, alarm on 4th, good clears alarm.
    frame(1, 3, 0, 10);
    for (int k = 0; k < 5; k++) begin
      frame(1, 3, 1, 20 + k);
      if (k == 3) begin
        d4 = dcyc;
        upto(d4 + 4);
        chk("l1_err4_pulse", er[1], 1);
        chk("l1_alarm_pre", al[1], 0);
        @(negedge clk);
        chk("l1_alarm_set", al[1], 1);
      end
    end
    upto(dcyc + 6);
    chk("l1_err_pulses", ern[1], 5);
    chk("l1_cnt5", cnt[31:16], 5);
    chk("l1_alarm_hold", al[1], 1);
    frame(1, 3, 0, 30);
    upto(dcyc + 4);
    chk("l1_good_pulse", ok[1], 1);
    chk("l1_alarm_still", al[1], 1);
    @(negedge clk);
    chk("l1_alarm_clr", al[1], 0);
    chk("l1_cnt_keep", cnt[31:16], 5);

    // Clear coinciding with an error pulse.
    for (int k = 0; k < 4; k++) frame(1, 2, 1, 40 + k);
    upto(dcyc + 6);
    chk("clr_alarm_pre", al[1], 1);
    frame(1, 2, 1, 50);
    upto(dcyc + 4);
    chk("clr_err_pulse", er[1], 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt", cnt[31:16], 0);
    chk("clr_alarm", al[1], 0);

    // Saturation: 6 bad on lane 0; the CNT_W=2 copy holds at 3.
    for (int k = 0; k < 6; k++) frame(0, 2, 1, 60 + k);
    upto(dcyc + 6);
    chk("sat_cnt16", cnt[15:0], 6);
    chk("sat_cnt2", cnt2, 3);
    chk("sat_alarm", al[0], 1);
    chk("sat_alarm2", al2, 1);

    // Random gaps, one-word frames, lane 2 disabled after bad diag.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int l = 0; l < 4; l++) begin
      mcrc[l] = 32'hFFFFFFFF;
      mchk[l] = (l < 2);
      merr[l] = 0;
      for (int j = 0; j < 8; j++) begin
        rok[l][j] = 1'b0;
        rer[l][j] = 1'b0;
      end
    end
    for (int s = 0; s < 88; s++) begin
      c = cyc;
      eo = '0;
      ee = '0;
      for (int l = 0; l < 4; l++) begin
        eo[l] = rok[l][c % 8];
        ee[l] = rer[l][c % 8];
        if (ee[l]) merr[l]++;
        rok[l][c % 8] = 1'b0;
        rer[l][c % 8] = 1'b0;
      end
      chk("rnd_ok", ok, eo);
      chk("rnd_err", er, ee);
      for (int l = 0; l < 4; l++) begin
        if (l == 2 && s == 42) begin
          en[2] = 1'b0;
          mchk[2] = 1'b0;
          for (int j = 0; j < 8; j++) begin
            rok[2][j] = 1'b0;
            rer[2][j] = 1'b0;
          end
        end
        f = (s < 80) && (s == 0 || (s == 40 && l == 2) ||
                         ($urandom % 4) != 0);
        d = f && (s == 0 || (s == 40 && l == 2) || ($urandom % 3) == 0);
        if (l == 2 && s >= 42) f = 1'b0;
        w = {$urandom, $urandom};
        if (f && d) begin
          fin = step(mcrc[l], {w[63:32], 32'h0});
          b = (s == 40 && l == 2) ? 1'b1 : 1'($urandom % 2);
          w[31:0] = ~fin ^ {31'b0, b};
          if (mchk[l]) begin
            rok[l][(c + 4) % 8] = !b;
            rer[l][(c + 4) % 8] = b;
          end
          mchk[l] = 1'b1;
          mcrc[l] = 32'hFFFFFFFF;
        end else if (f) begin
          mcrc[l] = step(mcrc[l], w);
        end
        din[64*l +: 64] = w;
        fresh[l] = f;
        diag[l]  = f && d;
      end
      @(negedge clk);
    end
    fresh = '0;
    diag  = '0;
    for (int l = 0; l < 4; l++)
      chk($sformatf("rnd_cnt%0d", l), cnt[16*l +: 16], 64'(merr[l]));
    en = 4'hF;

    // Async reset mid-metaframe, then first diag only resyncs.
    for (int i = 0; i < 3; i++) put(0, mkw(70, i), 1'b0);
    arst_n = 1'b0;
    #2;
    chk("arst_ok", {ok, er}, 0);
    chk("arst_alarm", al, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_cnt2", {cnt2, al2}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    okb = okn[0] + ern[0];
    frame(0, 1, 0, 80);
    upto(dcyc + 6);
    chk("arst_silent", okn[0] + ern[0] - okb, 0);
    frame(0, 4, 0, 81);
    upto(dcyc + 4);
    chk("arst_then_ok", ok[0], 1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
